// File: rtl/stim_pkg.sv
// Shared types and defaults for the control-line stimulus sequencer.
// The FSM state type, default parameters and an address-width helper.
package stim_pkg;

  typedef enum logic {
    IDLE,
    PLAY
  } stim_state_t;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_HOLD_W = 16;

  localparam logic [DEF_NUM_CH-1:0] DEF_IDLE_VAL = '1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ctrl_stimulus_seq_if.sv
// Script-load / playback bus of the stimulus sequencer.
// master: bench or host side; slave: the sequencer.
interface ctrl_stimulus_seq_if
  import stim_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W
) ();

  localparam int ADDR_W = addr_w(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [HOLD_W-1:0] wr_hold;
  logic [NUM_CH-1:0] wr_vec;
  logic [ADDR_W-1:0] last_step;
  logic              loop_en;
  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] ctrl_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;
  logic              wr_err;

  modport master (
    output wr_en, wr_addr, wr_hold, wr_vec,
    output last_step, loop_en, start, abort,
    input  ctrl_out, busy, done, step_idx, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_hold, wr_vec,
    input  last_step, loop_en, start, abort,
    output ctrl_out, busy, done, step_idx, wr_err
  );

endinterface

// File: rtl/stim_step_ram.sv
// Script store: DEPTH x {hold, vec}, async reset to {0, IDLE_VAL}.
// One write port, one combinational read port.
module stim_step_ram
  import stim_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter logic [NUM_CH-1:0] IDLE_VAL = '1,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [HOLD_W-1:0] whold,
  input  logic [NUM_CH-1:0] wvec,
  input  logic [ADDR_W-1:0] raddr,
  output logic [HOLD_W-1:0] rhold,
  output logic [NUM_CH-1:0] rvec
);

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic [NUM_CH-1:0] vec;
  } step_t;

  step_t mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{hold: '0, vec: IDLE_VAL};
      end
    end else if (we) begin
      mem[waddr] <= '{hold: whold, vec: wvec};
    end
  end

  assign rhold = mem[raddr].hold;
  assign rvec  = mem[raddr].vec;

endmodule

// File: rtl/ctrl_stimulus_seq.sv
// Control-line sequencer: replays {hold, vec} steps onto active-low lines.
// Ports: Clk, Reset (async, low), bus (slave) for script load and playback.
module ctrl_stimulus_seq
  import stim_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter logic [NUM_CH-1:0] IDLE_VAL = '1
) (
  input logic          Clk,
  input logic          Reset,
  ctrl_stimulus_seq_if.slave bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);

  stim_state_t       state;
  logic [HOLD_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;
  logic              loop_q;
  logic [NUM_CH-1:0] ctrl_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              we;
  logic [ADDR_W-1:0] nxt_idx;
  logic [ADDR_W-1:0] raddr;
  logic [HOLD_W-1:0] rhold;
  logic [NUM_CH-1:0] rvec;
  logic [HOLD_W-1:0] s0_hold;
  logic [NUM_CH-1:0] s0_vec;
  logic [ADDR_W-1:0] last_cl;
  logic              at_last;

  assign we      = bus.wr_en && (state == IDLE);
  assign at_last = (idx == last_q);
  assign nxt_idx = at_last ? '0 : idx + ADDR_W'(1);
  assign raddr   = (state == PLAY) ? nxt_idx : '0;

  assign last_cl = (bus.last_step > MAX_IDX) ? MAX_IDX
                                             : bus.last_step;

  // A write to step 0 in the start cycle must reach playback.
  always_comb begin
    s0_hold = rhold;
    s0_vec  = rvec;
    if (we && bus.wr_addr == '0) begin
      s0_hold = bus.wr_hold;
      s0_vec  = bus.wr_vec;
    end
  end

  stim_step_ram #(
    .NUM_CH  (NUM_CH),
    .DEPTH   (DEPTH),
    .HOLD_W  (HOLD_W),
    .IDLE_VAL(IDLE_VAL),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .Clk  (Clk),
    .Reset(Reset),
    .we   (we),
    .waddr(bus.wr_addr),
    .whold(bus.wr_hold),
    .wvec (bus.wr_vec),
    .raddr(raddr),
    .rhold(rhold),
    .rvec (rvec)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      ctrl_q <= IDLE_VAL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= bus.wr_en && (state == PLAY);
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state  <= PLAY;
            idx    <= '0;
            cnt    <= s0_hold;
            ctrl_q <= s0_vec;
            busy_q <= 1'b1;
            last_q <= last_cl;
            loop_q <= bus.loop_en;
          end
        end
        PLAY: begin
          if (bus.abort) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            ctrl_q <= IDLE_VAL;
            busy_q <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
          end else if (at_last && !loop_q) begin
            state  <= IDLE;
            idx    <= '0;
            ctrl_q <= IDLE_VAL;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx    <= nxt_idx;
            cnt    <= rhold;
            ctrl_q <= rvec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_out = ctrl_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = idx;
  assign bus.wr_err   = err_q;

endmodule

// File: tb/tb_ctrl_stimulus_seq.sv
// Bench for ctrl_stimulus_seq: vector table plus directed sequences.
// Outputs are sampled 1 ns after the rising edge.
module tb_ctrl_stimulus_seq;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   npass = 0;
  int   ntot  = 0;

  always #10 Clk = ~Clk;

  ctrl_stimulus_seq_if #(.NUM_CH(2), .DEPTH(8), .HOLD_W(16)) bus ();

  ctrl_stimulus_seq #(
    .NUM_CH(2), .DEPTH(8), .HOLD_W(16), .IDLE_VAL(2'b11)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] h;
    logic [1:0]  v;
    logic        st;
    logic        ab;
    logic [2:0]  last;
    logic        lp;
    logic [1:0]  e_ctrl;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_idx;
    logic        e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic idle_in();
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_hold = 0; bus.wr_vec = 0;
    bus.start = 0; bus.abort = 0; bus.last_step = 0; bus.loop_en = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    idle_in();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] h,
                    input logic [1:0] v);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_hold = h; bus.wr_vec = v;
    tick();
  endtask

  task automatic go(input logic [2:0] last, input logic lp);
    bus.start = 1; bus.last_step = last; bus.loop_en = lp;
    tick();
  endtask

  function automatic logic [7:0] outs();
    return {bus.ctrl_out, bus.busy, bus.done, bus.step_idx};
  endfunction

  initial begin
    logic [1:0] lseq [7];
    int n;

    //            wr a  h   v     st ab last lp  ctrl  bsy dn idx err
    tbl[0]  = '{1, 0, 4, 2'b10, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 9, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b11, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b11, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0};

    idle_in();
    repeat (5) @(posedge Clk);
    #1;
    chk("por_ctrl", 32'(bus.ctrl_out), 32'h3);
    chk("por_busy", 32'(bus.busy), 32'h0);
    chk("por_done", 32'(bus.done), 32'h0);
    chk("por_idx", 32'(bus.step_idx), 32'h0);
    chk("por_err", 32'(bus.wr_err), 32'h0);
    @(negedge Clk);
    Reset = 1;
    tick();

    for (int i = 0; i < 13; i++) begin
      bus.wr_en = tbl[i].wr; bus.wr_addr = tbl[i].a;
      bus.wr_hold = tbl[i].h; bus.wr_vec = tbl[i].v;
      bus.start = tbl[i].st; bus.abort = tbl[i].ab;
      bus.last_step = tbl[i].last; bus.loop_en = tbl[i].lp;
      tick();
      chk($sformatf("tbl%0d", i), {24'h0, outs()},
          {24'h0, tbl[i].e_ctrl, tbl[i].e_busy, tbl[i].e_done,
           tbl[i].e_idx});
      chk($sformatf("tbl%0d_err", i), 32'(bus.wr_err),
          32'(tbl[i].e_err));
    end

    // Loop mode, then abort.
    wr(0, 0, 2'b01);
    wr(1, 1, 2'b11);
    go(1, 1);
    lseq = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("loop%0d", i), 32'(bus.ctrl_out), 32'(lseq[i]));
      if (i < 6) tick();
    end
    bus.abort = 1;
    tick();
    chk("loop_abort", {30'h0, bus.ctrl_out}, 32'h3);
    chk("loop_abort_bd", {30'h0, bus.busy, bus.done}, 32'h0);
    tick();
    chk("loop_abort_nodone", 32'(bus.done), 32'h0);

    // Write while busy is rejected.
    go(1, 1);
    wr(0, 16'h5, 2'b00);
    chk("busy_wr_err", 32'(bus.wr_err), 32'h1);
    tick();
    chk("busy_wr_err_clr", 32'(bus.wr_err), 32'h0);
    bus.abort = 1;
    tick();
    go(0, 0);
    chk("reread_vec", {24'h0, outs()}, {24'h0, 2'b01, 1'b1, 1'b0, 3'd0});
    tick();
    chk("reread_done", {24'h0, outs()}, {24'h0, 2'b11, 1'b0, 1'b1, 3'd0});

    // Write and start in the same cycle.
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_hold = 2; bus.wr_vec = 2'b00;
    go(0, 0);
    n = 0;
    while (bus.busy && n < 10) begin
      if (bus.ctrl_out == 2'b00) n++;
      tick();
    end
    chk("wrstart_len", 32'(n), 32'd3);
    chk("wrstart_done", 32'(bus.done), 32'h1);

    // Asynchronous reset in mid-playback.
    wr(0, 1, 2'b10);
    wr(1, 1, 2'b01);
    wr(2, 1, 2'b00);
    go(2, 0);
    tick();
    tick();
    chk("mid_step1", {24'h0, outs()}, {24'h0, 2'b01, 1'b1, 1'b0, 3'd1});
    @(negedge Clk);
    Reset = 0;
    #1;
    chk("rst_async", {24'h0, outs()}, {24'h0, 2'b11, 1'b0, 1'b0, 3'd0});
    @(negedge Clk);
    Reset = 1;
    tick();
    go(0, 0);
    chk("rst_script", {24'h0, outs()}, {24'h0, 2'b11, 1'b1, 1'b0, 3'd0});
    tick();
    chk("rst_done", {24'h0, outs()}, {24'h0, 2'b11, 1'b0, 1'b1, 3'd0});

    // Longest possible step.
    wr(0, 16'hFFFF, 2'b10);
    go(0, 0);
    n = 0;
    while (bus.busy && n < 70000) begin
      if (bus.ctrl_out == 2'b10) n++;
      tick();
    end
    chk("maxhold_len", 32'(n), 32'd65536);
    chk("maxhold_done", {30'h0, bus.done, bus.busy}, 32'h2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
